exec_stage: RTL and testbench
=============================

Name: exec_stage

Overview:
- Execute stage of the 24-bit in-order pipeline; sits between the ID/EX register and the memory stage.
- Selects ALU operands from register reads, PC, immediate, or forwarded values, then computes the ALU result plus zero/negative flags.
- Registers the result together with the passthrough control fields into a packed EX/MEM word (bufferOut) for the memory stage.

Parameters:
- N, 24, datapath width (register data, PC, immediate, ALU result).
- BW, 64, packed output width; must equal 16 + 2*N.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- en  in  1  output-register enable (1 = capture, 0 = hold).
- rd1  in  N  register operand A.
- rd2  in  N  register operand B.
- rd3  in  N  store data / third register value; passed through.
- pc  in  N  current PC (operand A for branches).
- imm  in  N  sign-extended immediate.
- aluOut  in  N  forwarded ALU result from EX/MEM.
- result  in  N  forwarded writeback result.
- aluControl  in  4  ALU operation select.
- Rc  in  4  destination register index; passed through.
- immSrc  in  1  1 = operand B is imm.
- branchFlag  in  1  1 = operand A is pc; passed through.
- memWrite  in  1  passed through.
- memToReg  in  1  passed through.
- regWrite  in  1  passed through.
- Fa  in  1  forward select for operand A.
- Fb  in  1  forward select for operand B.
- opType  in  2  passed through.
- opCode  in  4  passed through.
- bufferOut  out  BW  registered EX/MEM word.

Behaviour:
- Operand A is selected by priority:
  - branchFlag=1 -> pc;
  - else Fa=1 -> aluOut;
  - else rd1.
- Operand B is selected by priority:
  - immSrc=1 -> imm;
  - else Fb=1 -> result;
  - else rd2.
- ALU ops (combinational, N-bit two's complement, wrap on overflow, carries discarded). The aluControl encodings are:
  - 0 SUB A-B;
  - 1 ADD A+B;
  - 2 AND;
  - 3 OR;
  - 4 CMP (result A-B, used for equality/ordering via flags);
  - 5 XOR;
  - 6 SLL A<<B[4:0];
  - 7 SRL logical A>>B[4:0];
  - 8 SRA;
  - 9 MUL (low N bits);
  - 10 pass B;
  - 11–15 result 0.
- Flags are computed from the N-bit ALU result for every op:
  - zeroFlag = (result == 0);
  - negFlag = result[N-1].
- bufferOut packing, LSB first:
  - [N-1:0] rd3;
  - [N+3:N] Rc;
  - [N+4] regWrite;
  - [N+5] memToReg;
  - [N+6] memWrite;
  - [N+7] branchFlag;
  - [N+8] negFlag;
  - [N+9] zeroFlag;
  - [2N+9:N+10] ALU result;
  - [2N+13:2N+10] opCode;
  - [2N+15:2N+14] opType.
  - With N=24: rd3 [23:0], Rc [27:24], regWrite 28, memToReg 29, memWrite 30, branchFlag 31, negFlag 32, zeroFlag 33, ALU [57:34], opCode [61:58], opType [63:62].
- Register timing:
  - Latency 1 cycle: inputs stable before rising edge k appear on bufferOut after edge k.
  - en=0 holds bufferOut unchanged.
- Reset:
  - rst=1 asynchronously clears bufferOut to all zeros, regardless of clk and en.
  - Reset has priority over en.
  - Reset asserted mid-operation discards in-flight data.
- No combinational path from inputs to bufferOut.

Test Plan:
- Reset: assert rst with en=1 and nonzero inputs -> bufferOut = 0 immediately; stays 0 through clock edges while rst=1.
- ADD: rd1=2, rd2=2, aluControl=1, Rc=3, rd3=0, opCode=1, opType=0, all selects 0, then one edge -> bufferOut fields:
  - ALU [57:34]=4, zero=0, neg=0;
  - Rc=3, rd3=0;
  - control bits 0;
  - opCode=1, opType=0.
- CMP equal: rd1=3, rd2=3, aluControl=4 -> ALU=0, zeroFlag=1, negFlag=0.
- SUB negative: rd1=2, rd2=3, aluControl=0 -> ALU=0xFFFFFF (-1), negFlag (bit 32)=1, zeroFlag=0.
- Operand muxing:
  - branchFlag=1, pc=1, rd2=1, aluControl=0 -> ALU=0, zero=1, bit 31=1.
  - immSrc=1, rd1=2, imm=2, aluControl=4 -> zero=1.
  - Fa=1, aluOut=7, rd1=0, rd2=2, ADD -> ALU=9.
  - Fb=1, result=5, rd2=0, rd1=1, ADD -> ALU=6.
- Enable hold: capture ADD result 4, then drop en=0 and change inputs -> bufferOut remains 4-result word across 3 edges; re-raising en captures new values next edge.

Source files
------------

// File: rtl/exec_stage.sv
`default_nettype none
// ============================================================================
//  Module   : exec_stage
//  Purpose  : Execute stage of the 24-bit in-order pipeline. Selects the ALU
//             operands (register reads, PC, immediate or forwarded values),
//             computes the ALU result with zero/negative flags and registers
//             it, together with the passthrough control fields, into the
//             packed EX/MEM word consumed by the memory stage.
//
//  Ports    : clk        - pipeline clock, rising-edge
//             rst        - asynchronous active-high reset (clears bufferOut)
//             en         - output register enable (1 capture, 0 hold)
//             rd1/rd2    - register operands A/B
//             rd3        - store data, passed through
//             pc         - current PC (operand A for branches)
//             imm        - sign-extended immediate (operand B when immSrc)
//             aluOut     - forwarded EX/MEM ALU result (operand A when Fa)
//             result     - forwarded writeback result (operand B when Fb)
//             aluControl - ALU operation select
//             Rc, regWrite, memToReg, memWrite, branchFlag,
//             opType, opCode - control fields passed through to EX/MEM
//             immSrc, Fa, Fb  - operand select controls
//             bufferOut  - registered EX/MEM word
//
//  Revision : 1.0 - initial release
// ============================================================================
module exec_stage #(
    parameter int N  = 24,
    parameter int BW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  rd1,
    input  logic [N-1:0]  rd2,
    input  logic [N-1:0]  rd3,
    input  logic [N-1:0]  pc,
    input  logic [N-1:0]  imm,
    input  logic [N-1:0]  aluOut,
    input  logic [N-1:0]  result,
    input  logic [3:0]    aluControl,
    input  logic [3:0]    Rc,
    input  logic          immSrc,
    input  logic          branchFlag,
    input  logic          memWrite,
    input  logic          memToReg,
    input  logic          regWrite,
    input  logic          Fa,
    input  logic          Fb,
    input  logic [1:0]    opType,
    input  logic [3:0]    opCode,
    output logic [BW-1:0] bufferOut
);

    // ------------------------------------------------------------------------
    // ALU operation encodings
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_ALU_SUB  = 4'd0;
    localparam logic [3:0] c_ALU_ADD  = 4'd1;
    localparam logic [3:0] c_ALU_AND  = 4'd2;
    localparam logic [3:0] c_ALU_OR   = 4'd3;
    localparam logic [3:0] c_ALU_CMP  = 4'd4;
    localparam logic [3:0] c_ALU_XOR  = 4'd5;
    localparam logic [3:0] c_ALU_SLL  = 4'd6;
    localparam logic [3:0] c_ALU_SRL  = 4'd7;
    localparam logic [3:0] c_ALU_SRA  = 4'd8;
    localparam logic [3:0] c_ALU_MUL  = 4'd9;
    localparam logic [3:0] c_ALU_PASB = 4'd10;

    // ------------------------------------------------------------------------
    // Operand selection
    // ------------------------------------------------------------------------
    logic [N-1:0] w_op_a;
    logic [N-1:0] w_op_b;
    logic [4:0]   w_shamt;

    // Branch target arithmetic takes precedence over forwarding on A, and an
    // immediate operand takes precedence over forwarding on B: forwarding only
    // ever replaces a register read.
    always_comb begin
        w_op_a = rd1;
        if (branchFlag) begin
            w_op_a = pc;
        end else if (Fa) begin
            w_op_a = aluOut;
        end
    end

    always_comb begin
        w_op_b = rd2;
        if (immSrc) begin
            w_op_b = imm;
        end else if (Fb) begin
            w_op_b = result;
        end
    end

    // Shift amount is the low five bits of B; amounts >= N shift everything out
    // (or fill with the sign for SRA).
    assign w_shamt = w_op_b[4:0];

    // ------------------------------------------------------------------------
    // ALU and flags
    // ------------------------------------------------------------------------
    logic [N-1:0] w_alu_res;
    logic         w_zero;
    logic         w_neg;

    always_comb begin
        w_alu_res = '0;
        case (aluControl)
            c_ALU_SUB:  w_alu_res = w_op_a - w_op_b;
            c_ALU_ADD:  w_alu_res = w_op_a + w_op_b;
            c_ALU_AND:  w_alu_res = w_op_a & w_op_b;
            c_ALU_OR:   w_alu_res = w_op_a | w_op_b;
            // CMP is a subtract whose only consumer is the flag pair.
            c_ALU_CMP:  w_alu_res = w_op_a - w_op_b;
            c_ALU_XOR:  w_alu_res = w_op_a ^ w_op_b;
            c_ALU_SLL:  w_alu_res = w_op_a << w_shamt;
            c_ALU_SRL:  w_alu_res = w_op_a >> w_shamt;
            c_ALU_SRA:  w_alu_res = $unsigned($signed(w_op_a) >>> w_shamt);
            // Only the low N bits of the product are kept.
            c_ALU_MUL:  w_alu_res = w_op_a * w_op_b;
            c_ALU_PASB: w_alu_res = w_op_b;
            default:    w_alu_res = '0;
        endcase
    end

    assign w_zero = (w_alu_res == '0);
    assign w_neg  = w_alu_res[N-1];

    // ------------------------------------------------------------------------
    // EX/MEM output register
    // ------------------------------------------------------------------------
    logic [BW-1:0] buffer_d;
    logic [BW-1:0] buffer_q;

    // Packed LSB first: rd3, Rc, regWrite, memToReg, memWrite, branchFlag,
    // negFlag, zeroFlag, ALU result, opCode, opType.
    always_comb begin
        buffer_d = buffer_q;
        if (en) begin
            buffer_d = {opType, opCode, w_alu_res, w_zero, w_neg,
                        branchFlag, memWrite, memToReg, regWrite, Rc, rd3};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buffer_q <= '0;
        end else begin
            buffer_q <= buffer_d;
        end
    end

    assign bufferOut = buffer_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exec_stage
//  Purpose  : Self-checking bench for exec_stage: directed scenarios followed
//             by randomized traffic checked against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_exec_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [23:0] rd1, rd2, rd3, pc, imm, aluOut, result;
    logic [3:0]  aluControl, Rc, opCode;
    logic        immSrc, branchFlag, memWrite, memToReg, regWrite, Fa, Fb;
    logic [1:0]  opType;
    logic [63:0] bufferOut;

    int total = 0;
    int bad   = 0;

    exec_stage #(.N(24), .BW(64)) dut (
        .clk(clk), .rst(rst), .en(en),
        .rd1(rd1), .rd2(rd2), .rd3(rd3), .pc(pc), .imm(imm),
        .aluOut(aluOut), .result(result), .aluControl(aluControl), .Rc(Rc),
        .immSrc(immSrc), .branchFlag(branchFlag), .memWrite(memWrite),
        .memToReg(memToReg), .regWrite(regWrite), .Fa(Fa), .Fb(Fb),
        .opType(opType), .opCode(opCode), .bufferOut(bufferOut)
    );

    always #5 clk = ~clk;

    // Behavioural reference: plain 64-bit integer arithmetic on the current
    // inputs, producing the word the register should capture.
    function automatic logic [63:0] model();
        longint mask = 64'h0000_0000_00FF_FFFF;
        longint a, b, r, sa, w;
        int     sh;
        a  = branchFlag ? longint'(pc) : (Fa ? longint'(aluOut) : longint'(rd1));
        b  = immSrc ? longint'(imm) : (Fb ? longint'(result) : longint'(rd2));
        sh = int'(b % 32);
        case (aluControl)
            4'd0, 4'd4: r = a - b;
            4'd1:       r = a + b;
            4'd2:       r = a & b;
            4'd3:       r = a | b;
            4'd5:       r = a ^ b;
            4'd6:       r = a << sh;
            4'd7:       r = a >> sh;
            4'd8: begin
                sa = (a >= 64'd8388608) ? a - 64'd16777216 : a;
                r  = sa >>> sh;
            end
            4'd9:       r = a * b;
            4'd10:      r = b;
            default:    r = 0;
        endcase
        r = r & mask;
        w = longint'(rd3)
          | (longint'(Rc)         << 24)
          | (longint'(regWrite)   << 28)
          | (longint'(memToReg)   << 29)
          | (longint'(memWrite)   << 30)
          | (longint'(branchFlag) << 31)
          | (longint'((r >> 23) & 1) << 32)
          | (longint'(r == 0)     << 33)
          | (r                    << 34)
          | (longint'(opCode)     << 58)
          | (longint'(opType)     << 62);
        return 64'(w);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        rd1 = '0; rd2 = '0; rd3 = '0; pc = '0; imm = '0; aluOut = '0; result = '0;
        aluControl = '0; Rc = '0; opCode = '0; opType = '0;
        immSrc = 0; branchFlag = 0; memWrite = 0; memToReg = 0; regWrite = 0;
        Fa = 0; Fb = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] exp_q;
    logic [63:0] held;
    logic [63:0] nxt;

    initial begin
        // ---------------- reset with live inputs ----------------
        clear_inputs();
        en = 1; rd1 = 24'h123456; rd2 = 24'h000777; rd3 = 24'hABCDEF;
        Rc = 4'hF; opCode = 4'h9; opType = 2'd3; regWrite = 1; aluControl = 4'd1;
        rst = 1;
        #2;
        chk("reset_async", bufferOut, 64'd0);
        tick();
        chk("reset_edge1", bufferOut, 64'd0);
        tick();
        chk("reset_edge2", bufferOut, 64'd0);
        rst = 0;

        // ---------------- ADD ----------------
        clear_inputs();
        rd1 = 24'd2; rd2 = 24'd2; aluControl = 4'd1; Rc = 4'd3; opCode = 4'd1;
        tick();
        chk("add_alu",   64'(bufferOut[57:34]), 64'd4);
        chk("add_flags", 64'(bufferOut[33:32]), 64'd0);
        chk("add_rc",    64'(bufferOut[27:24]), 64'd3);
        chk("add_ctrl",  64'(bufferOut[31:28]), 64'd0);
        chk("add_word",  bufferOut, 64'h0400_0010_0300_0000);

        // ---------------- CMP equal ----------------
        clear_inputs();
        rd1 = 24'd3; rd2 = 24'd3; aluControl = 4'd4;
        tick();
        chk("cmp_alu",  64'(bufferOut[57:34]), 64'd0);
        chk("cmp_zero", 64'(bufferOut[33]), 64'd1);
        chk("cmp_neg",  64'(bufferOut[32]), 64'd0);

        // ---------------- SUB negative ----------------
        clear_inputs();
        rd1 = 24'd2; rd2 = 24'd3; aluControl = 4'd0;
        tick();
        chk("sub_alu",  64'(bufferOut[57:34]), 64'h00FF_FFFF);
        chk("sub_neg",  64'(bufferOut[32]), 64'd1);
        chk("sub_zero", 64'(bufferOut[33]), 64'd0);

        // ---------------- operand muxing ----------------
        clear_inputs();
        branchFlag = 1; pc = 24'd1; rd1 = 24'd50; rd2 = 24'd1; aluControl = 4'd0;
        tick();
        chk("br_alu",  64'(bufferOut[57:34]), 64'd0);
        chk("br_zero", 64'(bufferOut[33]), 64'd1);
        chk("br_bit",  64'(bufferOut[31]), 64'd1);

        clear_inputs();
        immSrc = 1; rd1 = 24'd2; imm = 24'd2; rd2 = 24'd9; Fb = 1; result = 24'd11;
        aluControl = 4'd4;
        tick();
        chk("imm_zero", 64'(bufferOut[33]), 64'd1);

        clear_inputs();
        Fa = 1; aluOut = 24'd7; rd1 = 24'd0; rd2 = 24'd2; aluControl = 4'd1;
        tick();
        chk("fa_alu", 64'(bufferOut[57:34]), 64'd9);

        clear_inputs();
        Fb = 1; result = 24'd5; rd2 = 24'd0; rd1 = 24'd1; aluControl = 4'd1;
        tick();
        chk("fb_alu", 64'(bufferOut[57:34]), 64'd6);

        // ---------------- enable hold ----------------
        clear_inputs();
        rd1 = 24'd2; rd2 = 24'd2; aluControl = 4'd1; Rc = 4'd3; opCode = 4'd1;
        held = model();
        tick();
        chk("hold_capture", bufferOut, held);
        en = 0;
        rd1 = 24'd100; rd2 = 24'd55; aluControl = 4'd5; Rc = 4'd7; opType = 2'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_en0", bufferOut, held);
        end
        en = 1;
        nxt = model();
        tick();
        chk("hold_reenable", bufferOut, nxt);

        // ---------------- reset mid-operation ----------------
        rd1 = 24'd40; rd2 = 24'd1; aluControl = 4'd0; rd3 = 24'h00BEEF;
        #2;
        rst = 1;
        #1;
        chk("rst_mid_async", bufferOut, 64'd0);
        tick();
        chk("rst_mid_edge", bufferOut, 64'd0);
        rst = 0;
        #1;
        chk("rst_mid_release", bufferOut, 64'd0);
        nxt = model();
        tick();
        chk("rst_mid_recover", bufferOut, nxt);
        exp_q = nxt;

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 400; i++) begin
            rd1 = 24'($urandom); rd2 = 24'($urandom); rd3 = 24'($urandom);
            pc = 24'($urandom); imm = 24'($urandom);
            aluOut = 24'($urandom); result = 24'($urandom);
            if ($urandom_range(0, 3) == 0) rd2 = rd1;
            if ($urandom_range(0, 3) == 0) rd2 = 24'($urandom_range(0, 40));
            aluControl = 4'($urandom); Rc = 4'($urandom); opCode = 4'($urandom);
            opType = 2'($urandom);
            immSrc = 1'($urandom); branchFlag = 1'($urandom);
            memWrite = 1'($urandom); memToReg = 1'($urandom); regWrite = 1'($urandom);
            Fa = 1'($urandom); Fb = 1'($urandom);
            en = ($urandom_range(0, 3) != 0);
            nxt = model();
            tick();
            if (en) exp_q = nxt;
            chk("random", bufferOut, exp_q);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
